dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (target) end of the core's data-memory access path: accepts load/store requests from an initiator over a valid/ready handshake.
- Models memory latency with configurable wait states, then returns read data or write completion over a response handshake.
- Sits between the multi-cycle core's memory stage and a word-addressed storage array; replaces the zero-latency combinational data memory for latency-tolerant cores.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, at least 2.
- WAIT_STATES, 2, cycles inserted between request acceptance and response; 0 to 15.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; the block is reset while reset=0.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 means store, 0 means load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores.
- resp_err  output  1  access error flag; always 0 unless the optional feature is enabled.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Storage contents are not cleared.
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge, the request is accepted: req_write, req_addr and req_wdata are latched.
  - Counter is loaded with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the edge where counter==1, transition to RESP.
- Entering RESP (a single edge):
  - Store: array[index] <= latched wdata; resp_rdata <= 0.
  - Load: resp_rdata <= array[index].
  - resp_valid <= 1.
- Latency: request accepted at edge N gives resp_valid=1 after edge N+1+WAIT_STATES.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready=1 at an edge.
  - On that edge: resp_valid <= 0, resp_rdata <= 0, next state IDLE.
  - req_ready rises the following cycle; there is no back-to-back accept in the same edge.
- req_ready is a registered-state decode (req_ready = state==IDLE); it never depends combinationally on req_valid.
- Index = req_addr[log2(DEPTH_WORDS)+1 : 2].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Byte offset bits [1:0] are ignored unless the optional feature is enabled.
- The initiator must hold its request fields stable while req_valid=1 and req_ready=0.
  - Inputs are only sampled at the accept edge.
  - Changes during WAIT/RESP have no effect.
- req_valid in WAIT/RESP is ignored, not queued.
- resp_ready while resp_valid=0 is ignored.
- Reset asserted mid-operation:
  - A pending store not yet committed (state IDLE→WAIT) is dropped.
  - A store already committed on the RESP-entry edge remains in the array.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - A request with req_addr[1:0]!=0 is accepted and timed normally.
  - On RESP entry: resp_err=1, the store is suppressed (array unchanged), and resp_rdata=0.
  - Aligned requests give resp_err=0.
- Not defined:
  - resp_err is tied to 0.
  - Offset bits are ignored; the access uses the word at the index.

Decomposition:
- Shared package dmem_pkg:
  - State encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Word width constant 32.
  - Index-width function clog2.
- One sub-module, dmem_array:
  - Synchronous-write, synchronous-read storage of DEPTH_WORDS x 32.
  - Ports: clock, we, index, wdata, rdata.
  - Not reset.
- The FSM, counter and handshake stay in dmem_responder.

Test Plan (WAIT_STATES=2 unless noted):
- Store then load:
  - Store addr 0x0000_0010, data 0xDEAD_BEEF accepted at edge 1 → resp_valid=1 after edge 4, resp_rdata=0.
  - Load 0x10 → resp_rdata=0xDEAD_BEEF.
- Backpressure:
  - Load with resp_ready=0 for 5 cycles → resp_valid and resp_rdata held stable.
  - resp_ready=1 → resp_valid=0 next edge, req_ready=1.
- Wrap-around (DEPTH_WORDS=256):
  - Store 0x1234_5678 at 0x0000_0400, then load 0x0000_0000 → 0x1234_5678.
  - Load 0x0000_03FC → previous value, not modified.
- Zero wait states (WAIT_STATES=0): request accepted at edge N → resp_valid=1 after edge N+1.
- Reset mid-WAIT:
  - Store 0xAAAA_AAAA at 0x20; reset=0 one cycle after accept → req_ready=1, resp_valid=0.
  - A later load of 0x20 returns the old value.
- Misaligned (with DMEM_MISALIGN_ERR_EN):
  - Store 0xFFFF_FFFF at 0x0000_0022 → resp_err=1, array unchanged.
  - Without the macro: resp_err=0 and word 0x20 is written.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word width
// and the index-width helper.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a core's memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage behind the responder: synchronous write, synchronous read,
// contents deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    // Commit a store to the addressed word.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[index] <= wdata;
        end
    end

    // Registered read of the addressed word (old data on a same-cycle write).
    always_ff @(posedge clock) begin
        rdata <= mem_r[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles, then
// performs the access and holds the response. Optional: DMEM_MISALIGN_ERR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic               clock,
    input  logic               reset,
    dmem_responder_if.slave    bus
);

    localparam int IDX_W = clog2(DEPTH_WORDS);

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cnt_r;
    logic              req_ready_r;
    logic              wr_r;
    logic              misalign_r;
    logic              misalign_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  arr_idx_s;
    logic [WORD_W-1:0] wdata_r;
    logic [WORD_W-1:0] arr_rdata_s;
    logic              arr_we_s;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [WORD_W-1:0] resp_rdata_r;
    logic              accept_s;
    logic              access_s;
    logic              release_s;
    logic              unused_addr_s;

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign_s = (bus.req_addr[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    assign unused_addr_s = ^{bus.req_addr[WORD_W-1:IDX_W+2], bus.req_addr[1:0]};

    // The access happens on the first edge spent in RESP, before resp_valid is up.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        release_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = (WAIT_STATES == 0) ? RESP : WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (!resp_valid_r) begin
                    access_s     = 1'b1;
                    state_next_s = RESP;
                end else if (bus.resp_ready) begin
                    release_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and registered ready decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == IDLE);
        end
    end

    // Wait-state counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= 4'(WAIT_STATES);
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request fields are captured only on the accept edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_r       <= 1'b0;
            misalign_r <= 1'b0;
            idx_r      <= {IDX_W{1'b0}};
            wdata_r    <= 32'h0000_0000;
        end else if (accept_s) begin
            wr_r       <= bus.req_write;
            misalign_r <= misalign_s;
            idx_r      <= bus.req_addr[IDX_W+1:2];
            wdata_r    <= bus.req_wdata;
        end else begin
            wr_r       <= wr_r;
            misalign_r <= misalign_r;
            idx_r      <= idx_r;
            wdata_r    <= wdata_r;
        end
    end

    // While idle the array is pre-read at the incoming index so zero-wait loads have data.
    assign arr_idx_s = (state_r == IDLE) ? bus.req_addr[IDX_W+1:2] : idx_r;
    assign arr_we_s  = access_s & wr_r & ~misalign_r;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we_s),
        .index (arr_idx_s),
        .wdata (wdata_r),
        .rdata (arr_rdata_s)
    );

    // Response registers: loaded on the access edge, held until the initiator takes them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else if (access_s) begin
            resp_valid_r <= 1'b1;
            resp_err_r   <= misalign_r;
            resp_rdata_r <= (wr_r | misalign_r) ? 32'h0000_0000 : arr_rdata_s;
        end else if (release_s) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            resp_valid_r <= resp_valid_r;
            resp_err_r   <= resp_err_r;
            resp_rdata_r <= resp_rdata_r;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against
// a word-array reference model. Honours DMEM_MISALIGN_ERR_EN.
module tb_dmem_responder;

    localparam int WAIT_A = 2;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    logic [31:0] mem_m   [256];
    bit          known_m [256];

    dmem_responder_if ifa ();
    dmem_responder_if ifb ();

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WAIT_A)) dut_a (
        .clock (clock), .reset (reset), .bus (ifa.slave));

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_b (
        .clock (clock), .reset (reset), .bus (ifb.slave));

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference: a plain array of words, index = (addr/4) mod 256.
    task automatic model(input bit w, input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] exp_rd, output logic exp_err, output bit known);
        int idx;
        idx     = int'((addr / 32'd4) % 32'd256);
        exp_err = MIS_EN && ((addr % 32'd4) != 32'd0);
        known   = 1'b1;
        if (exp_err) begin
            exp_rd = 32'd0;
        end else if (w) begin
            mem_m[idx]   = data;
            known_m[idx] = 1'b1;
            exp_rd       = 32'd0;
        end else begin
            exp_rd = mem_m[idx];
            known  = known_m[idx];
        end
    endtask

    // Drive one transaction on dut_a; returns observations and model expectations.
    task automatic run(input bit w, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rd, output logic err, output int lat, output logic busy,
                       output logic [31:0] exp_rd, output logic exp_err, output bit known);
        model(w, addr, data, exp_rd, exp_err, known);
        @(negedge clock);
        ifa.req_valid = 1'b1; ifa.req_write = w; ifa.req_addr = addr; ifa.req_wdata = data;
        @(posedge clock); #1;
        busy = ifa.req_ready;
        ifa.req_valid = 1'b0;
        ifa.req_write = 1'($urandom_range(1)); ifa.req_addr = $urandom; ifa.req_wdata = $urandom;
        lat = 0; rd = 'x; err = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (ifa.resp_valid === 1'b1) begin
                lat = c; rd = ifa.resp_rdata; err = ifa.resp_err;
                break;
            end
            ifa.req_valid  = 1'($urandom_range(1));
            ifa.resp_ready = 1'($urandom_range(1));
        end
        if (lat == 0) lat = -1;
        ifa.req_valid  = 1'b0;
        ifa.resp_ready = 1'b1;
        @(posedge clock); #1;
        ifa.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        chk_cnt++; if (ifa.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", ifa.req_ready); else pass_cnt++;
        chk_cnt++; if (ifa.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", ifa.resp_valid); else pass_cnt++;
        chk_cnt++; if (ifa.resp_rdata !== 32'd0) $display("FAIL reset_resp_rdata: got %h want 0", ifa.resp_rdata); else pass_cnt++;
        chk_cnt++; if (ifa.resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", ifa.resp_err); else pass_cnt++;
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_store_load;
        logic [31:0] rd, erd; logic err, eerr, busy; int lat; bit kn;
        run(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (lat !== WAIT_A + 1) $display("FAIL st_latency: got %0d want %0d", lat, WAIT_A + 1); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL st_ready_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (rd !== 32'd0) $display("FAIL st_rdata: got %h want 0", rd); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL st_err: got %b want 0", err); else pass_cnt++;
        run(1'b0, 32'h0000_0010, 32'h0, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ld_rdata: got %h want deadbeef", rd); else pass_cnt++;
        chk_cnt++; if (lat !== WAIT_A + 1) $display("FAIL ld_latency: got %0d want %0d", lat, WAIT_A + 1); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clock);
        ifa.req_valid = 1'b1; ifa.req_write = 1'b0; ifa.req_addr = 32'h0000_0010; ifa.req_wdata = 32'd0;
        @(posedge clock); #1;
        ifa.req_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (ifa.resp_valid === 1'b1) begin lat = c; break; end
        end
        chk_cnt++; if (lat !== WAIT_A + 1) $display("FAIL bp_latency: got %0d want %0d", lat, WAIT_A + 1); else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            ifa.req_valid = 1'b1; ifa.req_addr = $urandom; ifa.req_write = 1'b1;
            @(posedge clock); #1;
            chk_cnt++; if (ifa.resp_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", ifa.resp_valid); else pass_cnt++;
            chk_cnt++; if (ifa.resp_rdata !== 32'hDEAD_BEEF) $display("FAIL bp_hold_rdata: got %h want deadbeef", ifa.resp_rdata); else pass_cnt++;
            chk_cnt++; if (ifa.req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", ifa.req_ready); else pass_cnt++;
        end
        ifa.req_valid = 1'b0; ifa.resp_ready = 1'b1;
        @(posedge clock); #1;
        ifa.resp_ready = 1'b0;
        chk_cnt++; if (ifa.resp_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", ifa.resp_valid); else pass_cnt++;
        chk_cnt++; if (ifa.req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", ifa.req_ready); else pass_cnt++;
        chk_cnt++; if (ifa.resp_rdata !== 32'd0) $display("FAIL bp_release_rdata: got %h want 0", ifa.resp_rdata); else pass_cnt++;
    endtask

    task automatic test_wrap;
        logic [31:0] rd, erd; logic err, eerr, busy; int lat; bit kn;
        run(1'b1, 32'h0000_03FC, 32'hCAFE_0001, rd, err, lat, busy, erd, eerr, kn);
        run(1'b1, 32'h0000_0400, 32'h1234_5678, rd, err, lat, busy, erd, eerr, kn);
        run(1'b0, 32'h0000_0000, 32'h0, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (rd !== 32'h1234_5678) $display("FAIL wrap_low: got %h want 12345678", rd); else pass_cnt++;
        run(1'b0, 32'h0000_03FC, 32'h0, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (rd !== 32'hCAFE_0001) $display("FAIL wrap_top_word: got %h want cafe0001", rd); else pass_cnt++;
        run(1'b0, 32'hABC0_0010, 32'h0, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (rd !== 32'hDEAD_BEEF) $display("FAIL wrap_upper_bits: got %h want deadbeef", rd); else pass_cnt++;
    endtask

    task automatic test_zero_wait;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            ifb.req_valid = 1'b1; ifb.req_write = (k == 0); ifb.req_addr = 32'h0000_0044; ifb.req_wdata = 32'h0BAD_F00D;
            @(posedge clock); #1;
            ifb.req_valid = 1'b0;
            chk_cnt++; if (ifb.resp_valid !== 1'b0) $display("FAIL zw_valid_at_n: got %b want 0", ifb.resp_valid); else pass_cnt++;
            chk_cnt++; if (ifb.req_ready !== 1'b0) $display("FAIL zw_ready_busy: got %b want 0", ifb.req_ready); else pass_cnt++;
            @(posedge clock); #1;
            chk_cnt++; if (ifb.resp_valid !== 1'b1) $display("FAIL zw_valid_at_n1: got %b want 1", ifb.resp_valid); else pass_cnt++;
            chk_cnt++; if (ifb.resp_rdata !== ((k == 0) ? 32'd0 : 32'h0BAD_F00D))
                $display("FAIL zw_rdata: got %h want %h", ifb.resp_rdata, (k == 0) ? 32'd0 : 32'h0BAD_F00D); else pass_cnt++;
            ifb.resp_ready = 1'b1;
            @(posedge clock); #1;
            ifb.resp_ready = 1'b0;
            chk_cnt++; if (ifb.req_ready !== 1'b1) $display("FAIL zw_ready_back: got %b want 1", ifb.req_ready); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd, erd; logic err, eerr, busy; int lat; bit kn;
        run(1'b1, 32'h0000_0020, 32'h5555_0000, rd, err, lat, busy, erd, eerr, kn);
        @(negedge clock);
        ifa.req_valid = 1'b1; ifa.req_write = 1'b1; ifa.req_addr = 32'h0000_0020; ifa.req_wdata = 32'hAAAA_AAAA;
        @(posedge clock); #1;
        ifa.req_valid = 1'b0;
        @(negedge clock); reset = 1'b0; #1;
        chk_cnt++; if (ifa.req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", ifa.req_ready); else pass_cnt++;
        chk_cnt++; if (ifa.resp_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", ifa.resp_valid); else pass_cnt++;
        @(negedge clock); reset = 1'b1;
        run(1'b0, 32'h0000_0020, 32'h0, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (rd !== 32'h5555_0000) $display("FAIL rst_mid_dropped: got %h want 55550000", rd); else pass_cnt++;
    endtask

    task automatic test_misalign;
        logic [31:0] rd, erd; logic err, eerr, busy; int lat; bit kn;
        run(1'b1, 32'h0000_0020, 32'h0123_4567, rd, err, lat, busy, erd, eerr, kn);
        run(1'b1, 32'h0000_0022, 32'hFFFF_FFFF, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (err !== MIS_EN) $display("FAIL mis_err: got %b want %b", err, MIS_EN); else pass_cnt++;
        chk_cnt++; if (lat !== WAIT_A + 1) $display("FAIL mis_latency: got %0d want %0d", lat, WAIT_A + 1); else pass_cnt++;
        run(1'b0, 32'h0000_0020, 32'h0, rd, err, lat, busy, erd, eerr, kn);
        chk_cnt++; if (rd !== (MIS_EN ? 32'h0123_4567 : 32'hFFFF_FFFF))
            $display("FAIL mis_word: got %h want %h", rd, MIS_EN ? 32'h0123_4567 : 32'hFFFF_FFFF); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL mis_aligned_err: got %b want 0", err); else pass_cnt++;
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, addr, data; logic err, eerr, busy; int lat; bit kn, w;
        for (int i = 0; i < 40; i++) begin
            w    = 1'($urandom_range(1));
            data = $urandom;
            addr = ($urandom << 10)
                 | (32'($urandom_range(7) + 248 * $urandom_range(1)) << 2)
                 | (($urandom_range(3) == 0) ? 32'($urandom_range(3, 1)) : 32'd0);
            run(w, addr, data, rd, err, lat, busy, erd, eerr, kn);
            chk_cnt++; if (lat !== WAIT_A + 1) $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, WAIT_A + 1); else pass_cnt++;
            chk_cnt++; if (busy !== 1'b0) $display("FAIL rnd_ready_busy[%0d]: got %b want 0", i, busy); else pass_cnt++;
            chk_cnt++; if (err !== eerr) $display("FAIL rnd_err[%0d]: addr %h got %b want %b", i, addr, err, eerr); else pass_cnt++;
            if (kn) begin
                chk_cnt++; if (rd !== erd) $display("FAIL rnd_rdata[%0d]: addr %h got %h want %h", i, addr, rd, erd); else pass_cnt++;
            end
        end
    endtask

    initial begin
        ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = 32'd0; ifa.req_wdata = 32'd0; ifa.resp_ready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = 32'd0; ifb.req_wdata = 32'd0; ifb.resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_m[i]   = 32'd0;
            known_m[i] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_backpressure();
        test_wrap();
        test_zero_wait();
        test_reset_mid_wait();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
